// File: rtl/bram_pkg.sv
// Shared types and helpers for the true-dual-port block-RAM model.
// Holds the write-mode enumeration and the byte-lane merge used by both
// the port output logic and the array write arbitration.
package bram_pkg;

    // Widest word and lane count any instance may use.
    localparam int MAX_W     = 72;
    localparam int MAX_LANES = MAX_W / 8;

    // How a port's output latch reacts to a write on that same port.
    typedef enum logic [1:0] {
        WM_WRITE_FIRST = 2'd0,
        WM_READ_FIRST  = 2'd1,
        WM_NO_CHANGE   = 2'd2
    } wmode_t;

    // Replace each byte of old_word whose enable bit is set with the
    // matching byte of new_word. Callers zero-extend narrower words.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]     old_word,
        input logic [MAX_W-1:0]     new_word,
        input logic [MAX_LANES-1:0] we
    );
        logic [MAX_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MAX_LANES; b++) begin
            if (we[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_port_out.sv
// Output side of one block-RAM port: the read latch, the optional output
// register and the asynchronous reset to the port's SRVAL. The write mode
// decides what the latch captures when this port writes.
module bram_port_out
    import bram_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                DO_REG     = 0,
    parameter wmode_t            WRITE_MODE = WM_WRITE_FIRST,
    parameter logic [DATA_W-1:0] SRVAL      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic              regce,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] latch_q;

    // Read latch: pure reads take the pre-write word, writes follow the write mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= SRVAL;
        end else if (en) begin
            if (!wr) begin
                latch_q <= old_word;
            end else begin
                case (WRITE_MODE)
                    WM_WRITE_FIRST: latch_q <= new_word;
                    WM_READ_FIRST:  latch_q <= old_word;
                    default:        latch_q <= latch_q;
                endcase
            end
        end
    end

    generate
        if (DO_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] oreg_q;

            // Second pipeline stage, advanced only by its own clock enable.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    oreg_q <= SRVAL;
                end else if (regce) begin
                    oreg_q <= latch_q;
                end
            end

            assign dout = oreg_q;
        end else begin : g_noreg
            logic unused_regce;
            assign unused_regce = regce;
            assign dout         = latch_q;
        end
    endgenerate

endmodule

// File: rtl/bram_tdp_model.sv
// Synthesisable true-dual-port block-RAM model with byte enables, per-port
// write modes, optional output registers and reset values.
// Optional feature: define BRAM_COLLISION_FLAG_EN to add the registered
// 'coll' output flagging same-address accesses with at least one writer.
module bram_tdp_model
    import bram_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                DEPTH        = 512,
    parameter int                DOA_REG      = 0,
    parameter int                DOB_REG      = 0,
    parameter wmode_t            WRITE_MODE_A = WM_WRITE_FIRST,
    parameter wmode_t            WRITE_MODE_B = WM_WRITE_FIRST,
    parameter logic [DATA_W-1:0] SRVAL_A      = '0,
    parameter logic [DATA_W-1:0] SRVAL_B      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     enb,
    input  logic [DATA_W/8-1:0]      wea,
    input  logic [DATA_W/8-1:0]      web,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    input  logic [DATA_W-1:0]        dina,
    input  logic [DATA_W-1:0]        dinb,
    input  logic                     regcea,
    input  logic                     regceb,
    output logic [DATA_W-1:0]        douta,
    output logic [DATA_W-1:0]        doutb
`ifdef BRAM_COLLISION_FLAG_EN
    ,
    output logic                     coll
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] old_b;
    logic [MAX_W-1:0]  merge_a_w;
    logic [MAX_W-1:0]  merge_b_w;
    logic [MAX_W-1:0]  merge_ab_w;
    logic [DATA_W-1:0] merged_a;
    logic [DATA_W-1:0] merged_b;
    logic [DATA_W-1:0] word_b;
    logic              wr_a;
    logic              wr_b;
    logic              same_addr;
    logic              unused_hi;

    // Both ports see the array as it was before this cycle's writes.
    assign old_a = mem[addra];
    assign old_b = mem[addrb];

    assign wr_a      = ena && (|wea);
    assign wr_b      = enb && (|web);
    assign same_addr = (addra == addrb);

    // Each port's own view of its write, used by a WRITE_FIRST latch.
    assign merge_a_w = byte_merge(MAX_W'(old_a), MAX_W'(dina), MAX_LANES'(wea));
    assign merge_b_w = byte_merge(MAX_W'(old_b), MAX_W'(dinb), MAX_LANES'(web));

    // Same-address double write: B's lanes are laid over A's result so B wins shared lanes.
    assign merge_ab_w = byte_merge(merge_a_w, MAX_W'(dinb), MAX_LANES'(web));

    assign merged_a  = merge_a_w[DATA_W-1:0];
    assign merged_b  = merge_b_w[DATA_W-1:0];
    assign word_b    = (wr_a && same_addr) ? merge_ab_w[DATA_W-1:0] : merged_b;
    assign unused_hi = ^{merge_a_w, merge_b_w, merge_ab_w};

    // Array writes; B's word is issued last so it is the one stored on a collision.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem[addra] <= merged_a;
        end
        if (wr_b) begin
            mem[addrb] <= word_b;
        end
    end

    bram_port_out #(
        .DATA_W     (DATA_W),
        .DO_REG     (DOA_REG),
        .WRITE_MODE (WRITE_MODE_A),
        .SRVAL      (SRVAL_A)
    ) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .en       (ena),
        .wr       (|wea),
        .regce    (regcea),
        .old_word (old_a),
        .new_word (merged_a),
        .dout     (douta)
    );

    bram_port_out #(
        .DATA_W     (DATA_W),
        .DO_REG     (DOB_REG),
        .WRITE_MODE (WRITE_MODE_B),
        .SRVAL      (SRVAL_B)
    ) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .en       (enb),
        .wr       (|web),
        .regce    (regceb),
        .old_word (old_b),
        .new_word (merged_b),
        .dout     (doutb)
    );

`ifdef BRAM_COLLISION_FLAG_EN
    // Flag a cycle where both ports hit one word and at least one of them writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll <= 1'b0;
        end else begin
            coll <= ena && enb && same_addr && ((|wea) || (|web));
        end
    end
`endif

endmodule

// File: tb/tb_bram_tdp_model.sv
// Self-checking bench for bram_tdp_model. Three instances with different
// write modes, output registers and reset values share one stimulus stream;
// a behavioural model predicts every output each cycle.
module tb_bram_tdp_model;
    import bram_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int NI    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena, enb, regcea, regceb;
    logic [1:0]    wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;
    logic [DW-1:0] douta [NI];
    logic [DW-1:0] doutb [NI];
`ifdef BRAM_COLLISION_FLAG_EN
    logic          coll [NI];
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [DW-1:0] mMem [DEPTH];
    logic [DW-1:0] expLatchA [NI];
    logic [DW-1:0] expRegA   [NI];
    logic [DW-1:0] expLatchB [NI];
    logic [DW-1:0] expRegB   [NI];
    logic          expColl;

    always #5 clk = ~clk;

    bram_tdp_model #(
        .DATA_W(DW), .DEPTH(DEPTH)
    ) u0 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .regcea(regcea), .regceb(regceb), .douta(douta[0]), .doutb(doutb[0])
`ifdef BRAM_COLLISION_FLAG_EN
        , .coll(coll[0])
`endif
    );

    bram_tdp_model #(
        .DATA_W(DW), .DEPTH(DEPTH), .DOA_REG(1),
        .WRITE_MODE_A(WM_READ_FIRST), .SRVAL_A(16'hFFFF)
    ) u1 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .regcea(regcea), .regceb(regceb), .douta(douta[1]), .doutb(doutb[1])
`ifdef BRAM_COLLISION_FLAG_EN
        , .coll(coll[1])
`endif
    );

    bram_tdp_model #(
        .DATA_W(DW), .DEPTH(DEPTH), .DOB_REG(1),
        .WRITE_MODE_A(WM_NO_CHANGE), .WRITE_MODE_B(WM_READ_FIRST), .SRVAL_B(16'h00A5)
    ) u2 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .regcea(regcea), .regceb(regceb), .douta(douta[2]), .doutb(doutb[2])
`ifdef BRAM_COLLISION_FLAG_EN
        , .coll(coll[2])
`endif
    );

    function automatic wmode_t cfgModeA(input int i);
        if (i == 0) return WM_WRITE_FIRST;
        if (i == 1) return WM_READ_FIRST;
        return WM_NO_CHANGE;
    endfunction

    function automatic wmode_t cfgModeB(input int i);
        return (i == 2) ? WM_READ_FIRST : WM_WRITE_FIRST;
    endfunction

    function automatic logic [DW-1:0] cfgSrvA(input int i);
        return (i == 1) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic logic [DW-1:0] cfgSrvB(input int i);
        return (i == 2) ? 16'h00A5 : 16'h0000;
    endfunction

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldw,
                                                 input logic [DW-1:0] neww,
                                                 input logic [1:0] we);
        logic [DW-1:0] mask;
        mask = {{8{we[1]}}, {8{we[0]}}};
        return (oldw & ~mask) | (neww & mask);
    endfunction

    function automatic logic [DW-1:0] nextLatch(input wmode_t mode, input logic en,
                                                input logic [1:0] we, input logic [DW-1:0] cur,
                                                input logic [DW-1:0] oldw, input logic [DW-1:0] merged);
        if (!en) return cur;
        if (we == 2'b00) return oldw;
        if (mode == WM_WRITE_FIRST) return merged;
        if (mode == WM_READ_FIRST) return oldw;
        return cur;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            expLatchA[i] = cfgSrvA(i);
            expRegA[i]   = cfgSrvA(i);
            expLatchB[i] = cfgSrvB(i);
            expRegB[i]   = cfgSrvB(i);
        end
        expColl = 1'b0;
    endtask

    // One clock edge of the model: outputs from pre-write contents, then memory updates A then B.
    task automatic modelStep();
        logic [DW-1:0] oldA, oldB;
        oldA = mMem[addra];
        oldB = mMem[addrb];
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (i == 1 && regcea) expRegA[i] = expLatchA[i];
                if (i == 2 && regceb) expRegB[i] = expLatchB[i];
                expLatchA[i] = nextLatch(cfgModeA(i), ena, wea, expLatchA[i], oldA, mergeBytes(oldA, dina, wea));
                expLatchB[i] = nextLatch(cfgModeB(i), enb, web, expLatchB[i], oldB, mergeBytes(oldB, dinb, web));
            end
            expColl = ena && enb && (addra == addrb) && (wea != 2'b00 || web != 2'b00);
        end
        if (ena) mMem[addra] = mergeBytes(mMem[addra], dina, wea);
        if (enb) mMem[addrb] = mergeBytes(mMem[addrb], dinb, web);
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("douta_u%0d", i), douta[i], (i == 1) ? expRegA[i] : expLatchA[i]);
            checkOutput($sformatf("doutb_u%0d", i), doutb[i], (i == 2) ? expRegB[i] : expLatchB[i]);
`ifdef BRAM_COLLISION_FLAG_EN
            checkOutput($sformatf("coll_u%0d", i), {15'b0, coll[i]}, {15'b0, expColl});
`endif
        end
    endtask

    // Drive one vector at the falling edge, then let the next rising edge consume it.
    task automatic applyStimulus(input logic ea, input logic [1:0] wa, input int aa, input logic [DW-1:0] da,
                                 input logic eb, input logic [1:0] wb, input int ab, input logic [DW-1:0] db,
                                 input logic rca, input logic rcb);
        @(negedge clk);
        ena = ea; wea = wa; addra = AW'(aa); dina = da;
        enb = eb; web = wb; addrb = AW'(ab); dinb = db;
        regcea = rca; regceb = rcb;
        @(posedge clk);
        #2;
    endtask

    // Model update and full comparison on every rising edge.
    always @(posedge clk) begin
        modelStep();
        #1;
        compareAll();
    end

    always @(posedge rst) modelReset();

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dina = 0; dinb = 0;
        regcea = 1; regceb = 1;
        for (int k = 0; k < DEPTH; k++) mMem[k] = '0;
        modelReset();
        #2;
        checkOutput("reset_u0_a", douta[0], 16'h0000);
        checkOutput("reset_u1_a", douta[1], 16'hFFFF);
        checkOutput("reset_u2_b", doutb[2], 16'h00A5);
        @(negedge clk);
        rst = 1'b0;

        // Basic write then cross-port read
        applyStimulus(1, 2'b11, 5, 16'hBEEF, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("wf_write_a", douta[0], 16'hBEEF);
        applyStimulus(0, 2'b00, 0, 16'h0, 1, 2'b00, 5, 16'h0, 1, 1);
        checkOutput("read_b_after_a", doutb[0], 16'hBEEF);

        // Byte enables
        applyStimulus(1, 2'b11, 7, 16'h1234, 0, 2'b00, 0, 16'h0, 1, 1);
        applyStimulus(1, 2'b01, 7, 16'hABCD, 0, 2'b00, 0, 16'h0, 1, 1);
        applyStimulus(1, 2'b00, 7, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("byte_enable", douta[0], 16'h12CD);

        // Write modes on addr 3
        applyStimulus(1, 2'b11, 3, 16'h0001, 0, 2'b00, 0, 16'h0, 1, 1);
        applyStimulus(1, 2'b11, 3, 16'h0002, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("wf_new_word", douta[0], 16'h0002);
        checkOutput("nc_hold", douta[2], 16'h12CD);
        applyStimulus(0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("rf_old_word", douta[1], 16'h0001);

        // Collisions on addr 9
        applyStimulus(1, 2'b11, 9, 16'h0000, 0, 2'b00, 0, 16'h0, 1, 1);
        applyStimulus(1, 2'b11, 9, 16'hAAAA, 1, 2'b11, 9, 16'h5555, 1, 1);
        checkOutput("wf_own_merged", douta[0], 16'hAAAA);
        checkOutput("wf_b_merged", doutb[0], 16'h5555);
`ifdef BRAM_COLLISION_FLAG_EN
        checkOutput("coll_flag", {15'b0, coll[0]}, 16'h0001);
`endif
        applyStimulus(1, 2'b00, 9, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("coll_b_wins", douta[0], 16'h5555);
        applyStimulus(1, 2'b11, 9, 16'h1122, 1, 2'b01, 9, 16'h3344, 1, 1);
        applyStimulus(1, 2'b00, 9, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("lane_merge", douta[0], 16'h1144);
        applyStimulus(1, 2'b11, 9, 16'h7788, 1, 2'b00, 9, 16'h0, 1, 1);
        checkOutput("other_port_old", doutb[0], 16'h1144);

        // Output register on port A of u1
        applyStimulus(1, 2'b00, 9, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        applyStimulus(0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("reg_flush", douta[1], 16'h7788);
        applyStimulus(1, 2'b00, 5, 16'h0, 0, 2'b00, 0, 16'h0, 0, 1);
        checkOutput("regce_low_hold", douta[1], 16'h7788);
        applyStimulus(0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0, 0, 1);
        applyStimulus(0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("regce_load", douta[1], 16'hBEEF);
        applyStimulus(1, 2'b00, 3, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("latency2_first", douta[1], 16'hBEEF);
        applyStimulus(0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("latency2_second", douta[1], 16'h0002);

        // Asynchronous reset in the middle of a read stream
        applyStimulus(1, 2'b00, 5, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_u1_a", douta[1], 16'hFFFF);
        checkOutput("rst_async_u0_a", douta[0], 16'h0000);
        checkOutput("rst_async_u2_b", doutb[2], 16'h00A5);
        applyStimulus(1, 2'b11, 11, 16'h7777, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("rst_hold_u0_a", douta[0], 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b0;
        wea = 2'b00;
        applyStimulus(1, 2'b00, 5, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("mem_kept", douta[0], 16'hBEEF);
        applyStimulus(1, 2'b00, 11, 16'h0, 0, 2'b00, 0, 16'h0, 1, 1);
        checkOutput("write_in_reset", douta[0], 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
